// File: rtl/occamy_ecc_scrubber_pkg.sv
// Shared types for the ECC scrubber: FSM encoding and the ecc_err_i bit layout.
package occamy_ecc_scrubber_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam int unsigned ErrCorr   = 0;
  localparam int unsigned ErrUncorr = 1;

  localparam logic [15:0] CntMax = 16'hFFFF;

endpackage

// File: rtl/occamy_ecc_scrubber.sv
// Background SRAM scrubber: periodically reads each word, writes back corrected data, counts errors.
// One read per interval; requests hold stable until gnt_i, and events pulse the cycle after rvalid_i.
module occamy_ecc_scrubber
  import occamy_ecc_scrubber_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [31:0]          interval_i,
  input  logic                 clear_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic [1:0]           ecc_err_i,
  output logic [1:0]           event_ecc_rerror_o,
  output logic [15:0]          corr_cnt_o,
  output logic [15:0]          uncorr_cnt_o,
  output logic [AddrWidth-1:0] last_err_addr_o,
  output logic                 busy_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e                 state_q, state_d;
  logic [31:0]            timer_q, timer_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [AddrWidth-1:0]   last_q, last_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [15:0]            corr_cnt_q, corr_cnt_d;
  logic [15:0]            uncorr_cnt_q, uncorr_cnt_d;
  logic [1:0]             event_q, event_d;
  logic                   resp_vld;
  logic                   resp_uncorr;
  logic                   resp_corr;
  logic [AddrWidth-1:0]   addr_next;

  // Uncorrectable dominates: 2'b11 never triggers a writeback.
  assign resp_vld    = (state_q == WAIT) && rvalid_i;
  assign resp_uncorr = resp_vld && ecc_err_i[ErrUncorr];
  assign resp_corr   = resp_vld && ecc_err_i[ErrCorr] && !ecc_err_i[ErrUncorr];
  assign addr_next   = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      last_q       <= '0;
      wdata_q      <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      event_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      wdata_q      <= wdata_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      event_q      <= event_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (!enable_i) begin
          timer_d = '0;
        end else if (timer_q >= interval_i) begin
          timer_d = '0;
          state_d = READ;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      READ: begin
        if (gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (resp_corr) begin
          wdata_d = rdata_i;
          state_d = WRITE;
        end else if (resp_vld) begin
          addr_d  = addr_next;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (gnt_i) begin
          addr_d  = addr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error bookkeeping; clear_i takes priority over a same-cycle increment.
  always_comb begin
    event_d      = '0;
    last_d       = last_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    event_d[ErrCorr]   = resp_corr;
    event_d[ErrUncorr] = resp_uncorr;
    if (resp_corr || resp_uncorr) last_d = addr_q;
    if (clear_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (resp_corr && corr_cnt_q != CntMax) corr_cnt_d = corr_cnt_q + 16'd1;
      if (resp_uncorr && uncorr_cnt_q != CntMax) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  assign req_o              = (state_q == READ) || (state_q == WRITE);
  assign we_o               = (state_q == WRITE);
  assign addr_o             = addr_q;
  assign wdata_o            = wdata_q;
  assign busy_o             = (state_q != IDLE);
  assign event_ecc_rerror_o = event_q;
  assign corr_cnt_o         = corr_cnt_q;
  assign uncorr_cnt_o       = uncorr_cnt_q;
  assign last_err_addr_o    = last_q;

endmodule

// File: tb/tb_occamy_ecc_scrubber.sv
// Randomized scoreboard bench: an SRAM responder predicts requests/events, a monitor checks them.
`timescale 1ns/1ps
module tb_occamy_ecc_scrubber;

  localparam int NW = 12;
  localparam int AW = 4;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic [31:0]   interval_i = '0;
  logic          clear_i = 1'b0;
  logic          req_o, we_o, busy_o;
  logic [AW-1:0] addr_o, last_err_addr_o;
  logic [DW-1:0] wdata_o;
  logic          gnt_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic [1:0]    ecc_err_i = '0;
  logic [1:0]    event_ecc_rerror_o;
  logic [15:0]   corr_cnt_o, uncorr_cnt_o;

  occamy_ecc_scrubber #(.NumWords(NW), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i),
    .clear_i(clear_i), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .ecc_err_i(ecc_err_i),
    .event_ecc_rerror_o(event_ecc_rerror_o), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o), .last_err_addr_o(last_err_addr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic [1:0]    evt;
    logic [15:0]   corr;
    logic [15:0]   uncorr;
    logic [AW-1:0] last;
  } evt_t;

  req_t req_q[$];
  evt_t evt_q[$];
  int   hs_cyc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int          m_addr = 0;
  logic [15:0] m_corr = '0, m_uncorr = '0;
  logic [AW-1:0] m_last = '0;
  bit          pend = 0;
  int          dly = 0;

  // Stimulus knobs
  int unsigned gnt_pct = 100, err_pct = 0, clr_pct = 0, max_dly = 0;
  bit          clr_on_resp = 0;
  bit          fix_en = 0;
  logic [1:0]  fix_err = 2'b00;
  bit          tgt_en = 0;
  int          tgt_addr = 0;
  logic [1:0]  tgt_err = 2'b00;

  // Monitor-side samples
  bit            smp_rd_hs = 0;
  bit            rv_seen = 0;
  bit            have_prev = 0;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic respond();
    logic [1:0]    e;
    logic [DW-1:0] d;
    evt_t          ev;
    int            r;
    d = {$urandom, $urandom};
    if (tgt_en && m_addr == tgt_addr) e = tgt_err;
    else if (fix_en) e = fix_err;
    else if ($urandom_range(0, 99) < err_pct) begin
      r = $urandom_range(0, 2);
      e = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11;
    end else e = 2'b00;
    rvalid_i  = 1'b1;
    rdata_i   = d;
    ecc_err_i = e;
    ev.evt = 2'b00;
    if (e[1]) begin
      ev.evt = 2'b10;
      if (!clear_i && m_uncorr != 16'hFFFF) m_uncorr = m_uncorr + 16'd1;
      m_last = AW'(m_addr);
    end else if (e[0]) begin
      ev.evt = 2'b01;
      if (!clear_i && m_corr != 16'hFFFF) m_corr = m_corr + 16'd1;
      m_last = AW'(m_addr);
      req_q.push_back('{we: 1'b1, addr: AW'(m_addr), data: d});
    end
    m_addr = (m_addr + 1) % NW;
    req_q.push_back('{we: 1'b0, addr: AW'(m_addr), data: '0});
    ev.corr = m_corr;
    ev.uncorr = m_uncorr;
    ev.last = m_last;
    evt_q.push_back(ev);
  endtask

  task automatic step();
    bit resp_now;
    @(posedge clk_i);
    #1;
    cyc++;
    if (smp_rd_hs) begin
      pend = 1;
      dly  = $urandom_range(0, max_dly);
    end
    resp_now = pend && (dly == 0);
    clear_i  = (clr_on_resp && resp_now) || ($urandom_range(0, 99) < clr_pct);
    if (clear_i) begin
      m_corr   = '0;
      m_uncorr = '0;
    end
    rvalid_i  = 1'b0;
    ecc_err_i = 2'b00;
    if (resp_now) begin
      respond();
      pend = 0;
    end else if (pend) dly--;
    gnt_i = ($urandom_range(0, 99) < gnt_pct);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    enable_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; ecc_err_i = '0; clear_i = 1'b0;
    req_q.delete();
    evt_q.delete();
    m_addr = 0; m_corr = '0; m_uncorr = '0; m_last = '0; pend = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_event", event_ecc_rerror_o, 0);
    chk("rst_corr", corr_cnt_o, 0);
    chk("rst_uncorr", uncorr_cnt_o, 0);
    chk("rst_last", last_err_addr_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    rst_ni = 1'b1;
    req_q.push_back('{we: 1'b0, addr: '0, data: '0});
  endtask

  task automatic drain();
    enable_i = 1'b0;
    gnt_pct  = 100;
    repeat (40) step();
    chk("drain_busy", busy_o, 0);
    chk("drain_req", req_o, 0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      rv_seen = 0; have_prev = 0; smp_rd_hs = 0;
    end else begin
      if (have_prev) begin
        chk("hold_req", req_o, 1);
        chk("hold_we", we_o, p_we);
        chk("hold_addr", addr_o, p_addr);
        chk("hold_wdata", wdata_o, p_wdata);
      end
      have_prev = req_o && !gnt_i;
      p_we = we_o; p_addr = addr_o; p_wdata = wdata_o;
      if (req_o && gnt_i) begin
        if (req_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          req_t x;
          x = req_q.pop_front();
          chk("req_we", we_o, x.we);
          chk("req_addr", addr_o, x.addr);
          if (x.we) chk("req_wdata", wdata_o, x.data);
        end
        if (!we_o) hs_cyc.push_back(cyc);
      end
      if (rv_seen) begin
        if (evt_q.size() == 0) chk("evt_unexpected", 1, 0);
        else begin
          evt_t y;
          y = evt_q.pop_front();
          chk("evt", event_ecc_rerror_o, y.evt);
          chk("corr_cnt", corr_cnt_o, y.corr);
          chk("uncorr_cnt", uncorr_cnt_o, y.uncorr);
          chk("last_addr", last_err_addr_o, y.last);
        end
      end else begin
        chk("evt_idle", event_ecc_rerror_o, 0);
      end
      rv_seen   = rvalid_i;
      smp_rd_hs = req_o && gnt_i && !we_o;
    end
  end

  initial begin
    bit seen;
    do_reset();

    // Fixed cadence: interval 3, immediate grant and response -> one read per 6 cycles
    interval_i = 32'd3; gnt_pct = 100; max_dly = 0; err_pct = 0;
    hs_cyc.delete();
    enable_i = 1'b1;
    repeat (60) step();
    drain();
    chk("cadence_count", hs_cyc.size() >= 8, 1);
    for (int i = 1; i < hs_cyc.size(); i++) chk("cadence_i3", hs_cyc[i] - hs_cyc[i-1], 6);

    // Back-to-back: interval 0 -> IDLE, READ, WAIT = 3 cycles
    interval_i = 32'd0;
    hs_cyc.delete();
    enable_i = 1'b1;
    repeat (30) step();
    drain();
    for (int i = 1; i < hs_cyc.size(); i++) chk("cadence_i0", hs_cyc[i] - hs_cyc[i-1], 3);

    // Directed: correctable on address 5, uncorrectable (2'b11) on address 7
    tgt_en = 1; tgt_addr = 5; tgt_err = 2'b01;
    enable_i = 1'b1;
    repeat (80) step();
    tgt_addr = 7; tgt_err = 2'b11;
    repeat (80) step();
    tgt_en = 0;
    drain();

    // Grant withheld while enable drops: request must hold, then complete
    interval_i = 32'd1; gnt_pct = 0; max_dly = 1;
    enable_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = req_o;
    end
    chk("stall_req_seen", seen, 1);
    enable_i = 1'b0;
    repeat (10) step();
    gnt_pct = 100;
    repeat (20) step();
    chk("stall_done_busy", busy_o, 0);

    // Saturation: preload counters near the top, then push past it
    drain();
    force dut.corr_cnt_q = 16'hFFFD;
    force dut.uncorr_cnt_q = 16'hFFFD;
    repeat (3) step();
    release dut.corr_cnt_q;
    release dut.uncorr_cnt_q;
    m_corr = 16'hFFFD; m_uncorr = 16'hFFFD;
    interval_i = 32'd0; max_dly = 0; fix_en = 1; fix_err = 2'b01;
    enable_i = 1'b1;
    repeat (30) step();
    fix_err = 2'b11;
    repeat (30) step();
    clr_on_resp = 1;
    repeat (12) step();
    clr_on_resp = 0; fix_en = 0;
    drain();

    // Randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      interval_i = $urandom_range(0, 4);
      gnt_pct = 50 + $urandom_range(0, 40);
      err_pct = 30; clr_pct = 3; max_dly = 2;
      for (int i = 0; i < 400; i++) begin
        enable_i = ($urandom_range(0, 19) != 0);
        step();
      end
      clr_pct = 0;
      drain();
    end

    // Reset in the middle of a read
    interval_i = 32'd0; gnt_pct = 100; max_dly = 2; err_pct = 30;
    enable_i = 1'b1;
    for (int i = 0; i < 50 && !pend; i++) step();
    chk("midrst_pending", pend, 1);
    do_reset();
    enable_i = 1'b1;
    repeat (100) step();
    drain();

    chk("end_req_q", req_q.size(), 1);
    chk("end_evt_q", evt_q.size(), 0);
    chk("end_pend", pend, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
